process_i_data_loader: RTL

//   Input-side counterpart of the FFT output serializer. Receives a byte stream from the

---
 rtl/process_i_data_loader_pkg.sv | 27 ++
 rtl/process_i_data_loader_sample_assembler.sv | 51 +++++
 rtl/process_i_data_loader.sv | 109 ++++++++++
 3 files changed

// File: rtl/process_i_data_loader_pkg.sv
// Shared types and helpers for the FFT input loader and output serializer.
package process_i_data_loader_pkg;

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_COLLECT = 5'b00010,
    S_WRITE   = 5'b00100,
    S_START   = 5'b01000,
    S_ABORT   = 5'b10000
  } state_t;

  // Byte slot order within a 4-byte complex sample on the UART link
  localparam logic [1:0] B_RE_LO = 2'd0;
  localparam logic [1:0] B_IM_LO = 2'd1;
  localparam logic [1:0] B_RE_HI = 2'd2;
  localparam logic [1:0] B_IM_HI = 2'd3;

  localparam int BITREV_MAX = 16;

  // Reverse the low 'size' bits of v; callers truncate to their own width.
  function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] v, input int size);
    logic [BITREV_MAX-1:0] r;
    for (int i = 0; i < BITREV_MAX; i++) r[i] = v[BITREV_MAX-1-i];
    return r >> (BITREV_MAX - size);
  endfunction

endpackage

// File: rtl/process_i_data_loader_sample_assembler.sv
// Collects four bytes into one sign-extended complex sample.
module sample_assembler
  import process_i_data_loader_pkg::*;
#(
  parameter int bit_width = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 byte_en,
  input  logic [7:0]           data_in,
  output logic                 last_slot,
  output logic                 sample_valid,
  output logic [bit_width-1:0] re,
  output logic [bit_width-1:0] im
);

  logic [1:0]      byte_cnt;
  logic [3:0][7:0] bytes;

  function automatic logic [bit_width-1:0] sext(input logic [7:0] hi, input logic [7:0] lo);
    return {{(bit_width-24){hi[7]}}, hi, lo, 8'h00};
  endfunction

  assign last_slot = (byte_cnt == B_IM_HI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt     <= '0;
      bytes        <= '0;
      re           <= '0;
      im           <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= byte_en && last_slot && !clr;
      if (clr) begin
        byte_cnt <= '0;
        bytes    <= '0;
      end else if (byte_en) begin
        bytes[byte_cnt] <= data_in;
        byte_cnt        <= byte_cnt + 2'd1;
        // b3 is taken straight from the bus so the sample is ready in the write cycle
        if (last_slot) begin
          re <= sext(bytes[B_RE_HI], bytes[B_RE_LO]);
          im <= sext(data_in, bytes[B_IM_LO]);
        end
      end
    end
  end

endmodule

// File: rtl/process_i_data_loader.sv
// UART byte stream -> FFT input memory loader with frame start and timeout abort.
module process_i_data_loader
  import process_i_data_loader_pkg::*;
#(
  parameter int bit_width = 28,
  parameter int N         = 16,
  parameter int SIZE      = 4,
  parameter int BIT_REV   = 1,
  parameter int TIMEOUT   = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           data_in,
  input  logic                 en_in,
  input  logic                 fft_ready,
  output logic                 wr_en_o,
  output logic [SIZE-1:0]      adr_o,
  output logic [bit_width-1:0] data_re_o,
  output logic [bit_width-1:0] data_im_o,
  output logic                 start_fft,
  output logic                 busy_o,
  output logic                 err_o,
  output logic                 overrun_o
);

  localparam int GW = $clog2(TIMEOUT);

  state_t          state, nxt;
  logic [SIZE-1:0] smp_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            byte_en, drop, last_slot, sample_valid, sample_done, last_smp, gap_to;

  assign last_smp    = (smp_cnt == SIZE'(N-1));
  assign gap_to      = (gap_cnt == GW'(TIMEOUT-1));
  assign sample_done = (state == S_COLLECT) && en_in && last_slot;

  sample_assembler #(.bit_width(bit_width)) u_asm (
    .clk          (clk),
    .rst          (rst),
    .clr          (state == S_ABORT),
    .byte_en      (byte_en),
    .data_in      (data_in),
    .last_slot    (last_slot),
    .sample_valid (sample_valid),
    .re           (data_re_o),
    .im           (data_im_o)
  );

  always_comb begin
    nxt     = state;
    byte_en = 1'b0;
    drop    = 1'b0;
    case (state)
      S_IDLE: if (en_in) begin
        if (fft_ready) begin
          byte_en = 1'b1;
          nxt     = S_COLLECT;
        end else drop = 1'b1;
      end
      S_COLLECT: begin
        if (en_in) begin
          byte_en = 1'b1;
          if (last_slot) nxt = S_WRITE;
        end else if (gap_to) nxt = S_ABORT;
      end
      S_WRITE: begin
        nxt = last_smp ? S_START : S_COLLECT;
        // a byte landing in the write cycle starts the next sample unless the frame is full
        if (en_in) begin
          if (last_smp) drop = 1'b1;
          else          byte_en = 1'b1;
        end
      end
      S_START: begin
        nxt  = S_IDLE;
        drop = en_in;
      end
      S_ABORT: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      smp_cnt   <= '0;
      gap_cnt   <= '0;
      adr_o     <= '0;
      busy_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      state  <= nxt;
      busy_o <= (nxt != S_IDLE);
      if (drop) overrun_o <= 1'b1;
      if (state == S_WRITE) smp_cnt <= smp_cnt + 1'b1;
      else if (state == S_IDLE || state == S_ABORT) smp_cnt <= '0;
      if (state == S_COLLECT && !en_in) begin
        if (!gap_to) gap_cnt <= gap_cnt + 1'b1;
      end else gap_cnt <= '0;
      if (sample_done)
        adr_o <= (BIT_REV != 0) ? SIZE'(bitrev(BITREV_MAX'(smp_cnt), SIZE)) : smp_cnt;
    end
  end

  assign wr_en_o   = sample_valid;
  assign start_fft = (state == S_START);
  assign err_o     = (state == S_ABORT);

endmodule
